moment_calc: RTL
================

Name: moment_calc

Overview:
- Downstream consumer of the LBM controller's moment phase, with D2Q9 lattice and row-major grid.
- On start, the block sweeps every cell of the fin memory and reads the 9 distribution values per cell.
- It accumulates density rho = sum f_i and momenta jx = sum f_i*cx_i, jy = sum f_i*cy_i.
- It writes results into the p, ux and uy memories at the cell address. The later velocity divide stage turns jx, jy into ux, uy.

Parameters:
- DATA_WIDTH, 32: signed fixed-point word width of f, rho, jx, jy.
- GRID_DIM, 256: number of lattice cells.
- Q, 9: directions per cell. Fixed at 9; the direction table is hard-coded.
- ADDRESS_WIDTH, $clog2(GRID_DIM): cell address width.
- FIN_ADDR_WIDTH, $clog2(GRID_DIM*Q): fin memory address width.

Ports:
- Clk, input, 1: clock; all logic is on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- start, input, 1: level request; connected to the controller's P load enable.
- fin_raddr, output, FIN_ADDR_WIDTH: fin read address = cell*9 + dir.
- fin_re, output, 1: fin read strobe.
- fin_rdata, input, DATA_WIDTH: fin read data, valid exactly 1 cycle after fin_re.
- wr_addr, output, ADDRESS_WIDTH: cell address for p/ux/uy writes.
- WE_p, WE_ux, WE_uy, output, 1 each: write strobes, always asserted together.
- rho_wdata, jx_wdata, jy_wdata, output, DATA_WIDTH each: write data.
- busy, output, 1: high in RUN and DRAIN.
- done, output, 1: high in DONE.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs 0, all counters and accumulators 0.
- Reset mid-sweep aborts the sweep immediately. There is no write in the cycle after reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DRAIN after the read for (GRID_DIM-1, dir 8) is issued.
  - DRAIN lasts 2 cycles, then -> DONE.
  - DONE -> IDLE when start=0.
- Read issue: in RUN, fin_re=1 every cycle, cell counter c and direction counter d (0..8), issuing back-to-back with no bubbles.
  - d wraps 8 -> 0 and c increments.
  - fin_raddr is kept as an incrementing counter, not a multiplier.
- Timing: start sampled in IDLE at cycle S.
  - The read for (c,d) is issued at S+1+9c+d; its data arrives at S+2+9c+d.
  - The write for cell c is at S+11+9c.
  - For GRID_DIM=256: last write at S+2306, done rises at S+2307. Throughput is 1 cell per 9 cycles.
- Direction table (cx,cy) in a shared package:
  - 0:(0,0), 1:(1,0), 2:(0,1), 3:(-1,0), 4:(0,-1)
  - 5:(1,1), 6:(-1,1), 7:(-1,-1), 8:(1,-1)
- Accumulation: the d tag is delayed 1 cycle alongside the data.
  - On dir-0 data the accumulators load (no add), so consecutive cells overlap without a bubble.
  - Each accumulation is add, subtract or hold according to cx/cy. No multipliers.
- Width: accumulators are DATA_WIDTH+4 bits signed.
  - On dir-8 data the final sum is formed and saturated to the signed DATA_WIDTH range ([-2^(W-1), 2^(W-1)-1]).
  - The result is registered, so the write strobes are 1 cycle after dir-8 data.
- Write outputs: WE_* is a single-cycle pulse per cell; wr_addr = c of that cell. Data and address hold their last value when WE=0.
- start deasserted during RUN/DRAIN is ignored; the sweep completes.
- start held high through DONE keeps done=1 and issues no new sweep. A new sweep requires start low for at least 1 cycle, then high.

Decomposition:
- Package lbm_pkg holds:
  - Q = 9;
  - the cx/cy direction tables as typedef'd signed 2-bit arrays;
  - the state enum type;
  - the saturate function.
- One natural sub-module: moment_accum, which takes the data, direction tag and first/last flags and returns saturated rho, jx, jy. The FSM and address generation stay in the top.

Test Plan:
- All f = 0x00010000 (1.0 Q16), start at cycle 0: 256 writes, rho = 0x00090000, jx = jy = 0. First WE at cycle 11, last at cycle 2306, done at 2307.
- Cell 5: f1 = 0x00010000, f5 = 0x00020000, others 0; all other cells 0: cell 5 gives rho = 0x00030000, jx = 0x00030000, jy = 0x00020000. All other cells write 0.
- All f = 0x7FFFFFFF: rho saturates to 0x7FFFFFFF, jx = jy = 0. All f = 0x80000000: rho = 0x80000000.
- Reset asserted 1 cycle at cycle 900 (mid cell 99): at cycle 901 all outputs are 0, state IDLE, no WE. A restart writes cell 0 first, 11 cycles after start is sampled.
- start held high after done: done stays 1 and no fin_re for 100 cycles. start low 1 cycle: done=0, IDLE. start high again: a new sweep begins.
- Per-cell distinct pattern f_i = cell*16 + i: every write matches a reference model sum, wr_addr increments 0..255 with no gaps, and WE_p/WE_ux/WE_uy are always equal.

Source files
------------

// File: rtl/lbm_pkg.sv
// lbm_pkg: shared D2Q9 lattice definitions.
// Direction tables, FSM state type and the saturating narrow helper.
package lbm_pkg;

  localparam int Q = 9;

  typedef logic signed [1:0] dir_t;
  typedef dir_t dir_tab_t [Q];

  localparam dir_tab_t CX = '{
    2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb00,
    2'sb01, 2'sb11, 2'sb11, 2'sb01
  };

  localparam dir_tab_t CY = '{
    2'sb00, 2'sb00, 2'sb01, 2'sb00, 2'sb11,
    2'sb01, 2'sb01, 2'sb11, 2'sb11
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Clamp a sign-extended sum into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/moment_calc_if.sv
// moment_calc_if: fin read port, p/ux/uy write port and control.
// master is the moment engine side, slave the memory/controller side.
interface moment_calc_if
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GRID_DIM   = 256
);
  localparam int ADDRESS_WIDTH  = $clog2(GRID_DIM);
  localparam int FIN_ADDR_WIDTH = $clog2(GRID_DIM * Q);

  logic                      start;
  logic [FIN_ADDR_WIDTH-1:0] fin_raddr;
  logic                      fin_re;
  logic [DATA_WIDTH-1:0]     fin_rdata;
  logic [ADDRESS_WIDTH-1:0]  wr_addr;
  logic                      WE_p;
  logic                      WE_ux;
  logic                      WE_uy;
  logic [DATA_WIDTH-1:0]     rho_wdata;
  logic [DATA_WIDTH-1:0]     jx_wdata;
  logic [DATA_WIDTH-1:0]     jy_wdata;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, fin_rdata,
    output fin_raddr, fin_re, wr_addr,
    output WE_p, WE_ux, WE_uy,
    output rho_wdata, jx_wdata, jy_wdata,
    output busy, done
  );

  modport slave (
    output start, fin_rdata,
    input  fin_raddr, fin_re, wr_addr,
    input  WE_p, WE_ux, WE_uy,
    input  rho_wdata, jx_wdata, jy_wdata,
    input  busy, done
  );

endinterface

// File: rtl/moment_accum.sv
// moment_accum: per-cell rho/jx/jy accumulation over 9 directions.
// Loads on dir 0, add/sub/hold per lattice vector, saturates on dir 8.
module moment_accum
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         in_valid,
  input  logic [3:0]                   in_dir,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] rho,
  output logic signed [DATA_WIDTH-1:0] jx,
  output logic signed [DATA_WIDTH-1:0] jy
);

  localparam int AW = DATA_WIDTH + 4;

  logic signed [AW-1:0] acc_rho_q;
  logic signed [AW-1:0] acc_jx_q;
  logic signed [AW-1:0] acc_jy_q;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] jx_b;
  logic signed [AW-1:0] jy_b;
  logic signed [AW-1:0] rho_d;
  logic signed [AW-1:0] jx_d;
  logic signed [AW-1:0] jy_d;
  dir_t                 cx;
  dir_t                 cy;

  // Next running sums: first direction restarts the cell, no bubble.
  always_comb begin
    ext  = {{4{in_data[DATA_WIDTH-1]}}, in_data};
    cx   = '0;
    cy   = '0;
    if (in_dir < 4'(Q)) begin
      cx = CX[in_dir];
      cy = CY[in_dir];
    end
    jx_b  = in_first ? '0 : acc_jx_q;
    jy_b  = in_first ? '0 : acc_jy_q;
    rho_d = in_first ? ext : acc_rho_q + ext;
    unique case (1'b1)
      cx == 2'sb01: jx_d = jx_b + ext;
      cx == 2'sb11: jx_d = jx_b - ext;
      default:      jx_d = jx_b;
    endcase
    unique case (1'b1)
      cy == 2'sb01: jy_d = jy_b + ext;
      cy == 2'sb11: jy_d = jy_b - ext;
      default:      jy_d = jy_b;
    endcase
  end

  // Accumulator registers and the registered, saturated cell result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_rho_q <= '0;
      acc_jx_q  <= '0;
      acc_jy_q  <= '0;
      out_valid <= 1'b0;
      rho       <= '0;
      jx        <= '0;
      jy        <= '0;
    end else begin
      out_valid <= in_valid & in_last;
      if (in_valid) begin
        acc_rho_q <= rho_d;
        acc_jx_q  <= jx_d;
        acc_jy_q  <= jy_d;
      end
      if (in_valid && in_last) begin
        rho <= DATA_WIDTH'(saturate(
          {{(64-AW){rho_d[AW-1]}}, rho_d}, DATA_WIDTH));
        jx  <= DATA_WIDTH'(saturate(
          {{(64-AW){jx_d[AW-1]}}, jx_d}, DATA_WIDTH));
        jy  <= DATA_WIDTH'(saturate(
          {{(64-AW){jy_d[AW-1]}}, jy_d}, DATA_WIDTH));
      end
    end
  end

endmodule

// File: rtl/moment_calc.sv
// moment_calc: sweeps fin memory cell by cell, 9 reads per cell,
// and writes rho/jx/jy for each cell into the p/ux/uy memories.
module moment_calc
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int GRID_DIM       = 256,
  parameter int ADDRESS_WIDTH  = $clog2(GRID_DIM),
  parameter int FIN_ADDR_WIDTH = $clog2(GRID_DIM * Q)
) (
  input logic          Clk,
  input logic          Reset,
  moment_calc_if.master bus
);

  state_t                    state_q;
  state_t                    state_d;
  logic [ADDRESS_WIDTH-1:0]  cell_q;
  logic [ADDRESS_WIDTH-1:0]  cell_d;
  logic [3:0]                dir_q;
  logic [3:0]                dir_d;
  logic [FIN_ADDR_WIDTH-1:0] raddr_q;
  logic [FIN_ADDR_WIDTH-1:0] raddr_d;
  logic                      drain_q;
  logic                      drain_d;
  logic                      last_rd;
  logic                      dir_wrap;

  logic                      rd_v_q;
  logic [3:0]                rd_dir_q;
  logic [ADDRESS_WIDTH-1:0]  rd_cell_q;
  logic [ADDRESS_WIDTH-1:0]  wr_addr_q;

  logic                      we_w;
  logic [DATA_WIDTH-1:0]     rho_w;
  logic [DATA_WIDTH-1:0]     jx_w;
  logic [DATA_WIDTH-1:0]     jy_w;

  assign dir_wrap = dir_q == 4'(Q - 1);
  assign last_rd  = dir_wrap
                 && cell_q == ADDRESS_WIDTH'(GRID_DIM - 1);

  // Sweep control: next state and read-address counters.
  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    dir_d   = dir_q;
    raddr_d = raddr_q;
    drain_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cell_d  = '0;
          dir_d   = '0;
          raddr_d = '0;
        end
      end
      S_RUN: begin
        raddr_d = raddr_q + FIN_ADDR_WIDTH'(1);
        if (dir_wrap) begin
          dir_d  = '0;
          cell_d = cell_q + ADDRESS_WIDTH'(1);
        end else begin
          dir_d  = dir_q + 4'd1;
        end
        if (last_rd) begin
          state_d = S_DRAIN;
          cell_d  = '0;
          raddr_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cell_q  <= '0;
      dir_q   <= '0;
      raddr_q <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      dir_q   <= dir_d;
      raddr_q <= raddr_d;
      drain_q <= drain_d;
    end
  end

  // Tags follow the read by one cycle to line up with fin_rdata.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_v_q    <= 1'b0;
      rd_dir_q  <= '0;
      rd_cell_q <= '0;
      wr_addr_q <= '0;
    end else begin
      rd_v_q    <= state_q == S_RUN;
      rd_dir_q  <= dir_q;
      rd_cell_q <= cell_q;
      if (rd_v_q && rd_dir_q == 4'(Q - 1))
        wr_addr_q <= rd_cell_q;
    end
  end

  moment_accum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_accum (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (rd_v_q),
    .in_dir    (rd_dir_q),
    .in_first  (rd_dir_q == 4'd0),
    .in_last   (rd_dir_q == 4'(Q - 1)),
    .in_data   (bus.fin_rdata),
    .out_valid (we_w),
    .rho       (rho_w),
    .jx        (jx_w),
    .jy        (jy_w)
  );

  assign bus.fin_re    = state_q == S_RUN;
  assign bus.fin_raddr = raddr_q;
  assign bus.busy      = state_q == S_RUN || state_q == S_DRAIN;
  assign bus.done      = state_q == S_DONE;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.WE_p      = we_w;
  assign bus.WE_ux     = we_w;
  assign bus.WE_uy     = we_w;
  assign bus.rho_wdata = rho_w;
  assign bus.jx_wdata  = jx_w;
  assign bus.jy_wdata  = jy_w;

endmodule
